// File: rtl/spi_tx_sched_pkg.sv
// Shared types and default build parameters for the SPI transmit scheduler.
package spi_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } sched_state_t;

    localparam int SPI_DATA_W    = 8;
    localparam int SCHED_N_REQ   = 4;
    localparam int SCHED_CS_GAP  = 3;
    localparam int SCHED_TIMEOUT = 64;

    // Bits needed for a counter that must hold values up to max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr_i, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr_i,
    output logic                     grant_valid_o,
    output logic [$clog2(N_REQ)-1:0] grant_idx_o
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W:0] cand_s;

    // Walk offsets from farthest to nearest so the nearest pending requester wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand_s        = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_s = {1'b0, rr_ptr_i} + (IDX_W+1)'(i);
            if (cand_s >= (IDX_W+1)'(N_REQ)) begin
                cand_s = cand_s - (IDX_W+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (req_i[cand_s[IDX_W-1:0]]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand_s[IDX_W-1:0];
            end else begin
                grant_valid_o = grant_valid_o;
                grant_idx_o   = grant_idx_o;
            end
        end
    end

endmodule

// File: rtl/spi_tx_sched.sv
// Round-robin scheduler sharing one SPI transmit shifter between N_REQ requesters,
// with a minimum CS-high gap between frames and a watchdog on hung frames.
module spi_tx_sched
    import spi_tx_sched_pkg::*;
#(
    parameter int N_REQ   = SCHED_N_REQ,
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CS_GAP  = SCHED_CS_GAP,
    parameter int TIMEOUT = SCHED_TIMEOUT
) (
    input  logic                      clk_100,
    input  logic                      a_rst_n,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]          ack_o,
    output logic [N_REQ-1:0]          done_o,
    output logic                      err_o,
    output logic                      spi_start_o,
    output logic [DATA_W-1:0]         spi_data_o,
    input  logic                      spi_busy_i,
    input  logic                      spi_done_i,
    output logic                      busy_o,
    output logic [$clog2(N_REQ)-1:0]  owner_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = cnt_w(TIMEOUT);
    localparam int GAP_W = cnt_w(CS_GAP);
    localparam sched_state_t DONE_NEXT = (CS_GAP == 0) ? IDLE : GAP;

    sched_state_t      state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              err_q, err_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic              grant_valid_s;
    logic [IDX_W-1:0]  grant_idx_s;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_i         (req_i),
        .rr_ptr_i      (rr_ptr_q),
        .grant_valid_o (grant_valid_s),
        .grant_idx_o   (grant_idx_s)
    );

    // Next-state and output-pulse logic; rr_ptr_q is the first index searched.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        data_d   = data_q;
        ack_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        start_d  = 1'b0;
        wd_d     = wd_q;
        gap_d    = gap_q;
        case (state_q)
            IDLE: begin
                if (grant_valid_s && !spi_busy_i) begin
                    ack_d    = N_REQ'(1) << grant_idx_s;
                    owner_d  = grant_idx_s;
                    data_d   = req_data_i[grant_idx_s*DATA_W +: DATA_W];
                    rr_ptr_d = (grant_idx_s == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);
                    state_d  = START;
                end else begin
                    state_d  = IDLE;
                end
            end
            START: begin
                start_d = 1'b1;
                wd_d    = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done arriving on the last watchdog cycle still counts as success.
                if (spi_done_i) begin
                    done_d  = N_REQ'(1) << owner_q;
                    gap_d   = '0;
                    state_d = DONE_NEXT;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    done_d  = N_REQ'(1) << owner_q;
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = DONE_NEXT;
                end else begin
                    wd_d    = wd_q + WD_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(CS_GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d   = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; async reset kills any frame in flight.
    always_ff @(posedge clk_100 or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            data_q   <= '0;
            ack_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            wd_q     <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            wd_q     <= wd_d;
            gap_q    <= gap_d;
        end
    end

    assign ack_o       = ack_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign spi_start_o = start_q;
    assign spi_data_o  = data_q;
    assign busy_o      = busy_q;
    assign owner_o     = owner_q;

endmodule
